fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC stage, directly downstream of the multicycle phase sequencer.
- Turns the sequencer's fetch and writeback strobes into a handshaked instruction-memory read and a PC update.
- Owns the program counter and the instruction register.
- Reports a busy indication back to the sequencer so it can stall on slow memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 255, max cycles in REQ+WAIT before the fetch is aborted (8-bit counter; 1..255 legal).

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  synchronous, active-low reset.
fetch_start  in  1  one-cycle strobe from sequencer: fetch the instruction at pc.
pc_update  in  1  one-cycle strobe from sequencer (writeback): load next PC.
pc_sel  in  2  next-PC source: 00 pc+4, 01 branch (pc+imm), 10 jalr ((rs1_val+imm)&~1), 11 hold.
branch_taken  in  1  qualifies pc_sel=01; 0 selects pc+4.
imm  in  32  sign-extended immediate from decode.
rs1_val  in  32  register-file rs1 value.
imem_req  out  1  read request; held until accepted.
imem_addr  out  32  read address; stable while imem_req=1.
imem_ready  in  1  memory accepts request this cycle.
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  read data.
pc  out  32  current PC.
pc_plus4  out  32  pc+4, combinational (for JAL/JALR link).
instr  out  32  instruction register.
instr_valid  out  1  instr holds a completed fetch of the current pc.
fetch_busy  out  1  high in any state other than IDLE.
fetch_err  out  1  sticky timeout flag.
misalign_err  out  1  one-cycle pulse: rejected misaligned next PC.

Behaviour:
- Reset (rst_n=0 at posedge) values, overriding everything including a fetch in progress:
  - pc=RESET_PC, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, imem_req=0, fetch_err=0, misalign_err=0.
  - state=IDLE, timeout counter=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on fetch_start go to REQ; imem_addr<=pc, instr_valid<=0, fetch_err<=0, counter<=0.
  - REQ: imem_req=1. On imem_ready go to WAIT. imem_rvalid in the same cycle as imem_ready is illegal and ignored; data arrives at earliest one cycle after acceptance.
  - WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_valid<=1, go to IDLE.
  - Counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT with no completion: go to IDLE, fetch_err<=1, imem_req<=0. instr keeps its old value; instr_valid stays 0.
- Latency: fetch_start at cycle N -> imem_req=1 from N+1. With ready at N+1 and rvalid at N+2, instr_valid=1 at N+3. fetch_busy=1 from N+1 through N+2.
- Next-PC computation is combinational; all adds are 32-bit wrap-around (0xFFFF_FFFC+4 = 0).
  - pc_sel=01 with branch_taken=0 gives pc+4.
  - pc_sel=11 gives pc (instr_valid unaffected).
- pc_update in IDLE:
  - If next_pc[1:0]==0: pc<=next_pc and instr_valid<=0 (unless pc_sel=11).
  - Otherwise pc is unchanged and misalign_err pulses high for exactly one cycle.
- pc_update or fetch_start while fetch_busy=1: ignored, with no state change. The sequencer must not do this; assertion-checked in the bench.
- pc_update and fetch_start in the same IDLE cycle:
  - PC update applies, and the fetch uses the new PC (imem_addr<=next_pc).
  - If next_pc is misaligned: the fetch uses the unchanged pc and misalign_err pulses.
- fetch_err clears only on the next accepted fetch_start or on reset.
- imem_addr changes only on entry to REQ; it is held through WAIT and IDLE.

Test Plan:
- Reset with RESET_PC=0x100, then fetch_start; ready at +1, rvalid at +2 with rdata=0x00500093 -> imem_addr=0x100, instr=0x00500093, instr_valid=1 at cycle +3, fetch_busy high 2 cycles.
- Backpressure: imem_ready low 5 cycles, then high; rvalid 3 cycles later -> imem_req held high 6 cycles, imem_addr stable at pc throughout, single capture.
- pc=0x200: pc_update with pc_sel=01, branch_taken=1, imm=0xFFFFFFF0 -> pc=0x1F0. Then pc_sel=10, rs1_val=0x301, imm=0 -> pc=0x300. Then pc_sel=01, imm=0x6 -> pc stays 0x300, misalign_err one-cycle pulse.
- TIMEOUT=4: fetch_start, never assert ready -> after 4 cycles in REQ, state IDLE, imem_req=0, fetch_err=1, instr unchanged. Next fetch_start clears fetch_err.
- Simultaneous pc_update (pc_sel=00, pc=0x10) and fetch_start -> pc=0x14, imem_addr=0x14. Also pull rst_n low during WAIT -> next cycle pc=RESET_PC, imem_req=0, instr=0x13, instr_valid=0.
- Wrap: pc=0xFFFF_FFFC, pc_update pc_sel=00 -> pc=0x0000_0000, pc_plus4=0x4, no misalign_err.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: turns sequencer fetch and writeback strobes into a
// handshaked instruction-memory read and a program-counter update.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_update,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_err,
    output logic        misalign_err
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;
    // Abort fires in the cycle where the counter would reach TIMEOUT.
    localparam logic [7:0]  CntLast  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_inc;
    logic [31:0] jalr_target;
    logic [31:0] next_pc;
    logic        next_misaligned;
    logic        pc_accept;

    // Next-PC selection; all adds wrap at 32 bits.
    always_comb begin
        pc_inc      = pc_q + 32'd4;
        jalr_target = (rs1_val + imm) & ~32'd1;
        next_pc     = pc_inc;
        case (pc_sel)
            2'b00:   next_pc = pc_inc;
            2'b01:   next_pc = branch_taken ? (pc_q + imm) : pc_inc;
            2'b10:   next_pc = jalr_target;
            default: next_pc = pc_q;
        endcase
        next_misaligned = (next_pc[1:0] != 2'b00);
        pc_accept       = pc_update && !next_misaligned;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        err_d      = err_q;
        misalign_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pc_update) begin
                    if (next_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                        if (pc_sel != 2'b11) begin
                            valid_d = 1'b0;
                        end
                    end
                end
                if (fetch_start) begin
                    state_d = StReq;
                    addr_d  = pc_accept ? next_pc : pc_q;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (imem_ready) begin
                    // Any rvalid in the acceptance cycle is ignored.
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (imem_rvalid) begin
                    state_d = StIdle;
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= NopInstr;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req     = (state_q == StReq);
    assign imem_addr    = addr_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_inc;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign fetch_busy   = (state_q != StIdle);
    assign fetch_err    = err_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, fetch completions checked by a scoreboard monitor.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_start, pc_update, branch_taken;
    logic [1:0]  pc_sel;
    logic [31:0] imm, rs1_val;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_busy, fetch_err, misalign_err;
    logic [31:0] imem_addr, pc, pc_plus4, instr;

    // Second instance with a short timeout and a memory that never answers.
    logic        t_fetch_start;
    logic        z1;
    logic [1:0]  z2;
    logic [31:0] z32;
    logic        t_req, t_valid, t_busy, t_err, t_mis;
    logic [31:0] t_addr, t_pc, t_pc4, t_instr;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_update(pc_update),
        .pc_sel(pc_sel), .branch_taken(branch_taken), .imm(imm), .rs1_val(rs1_val),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .instr_valid(instr_valid), .fetch_busy(fetch_busy),
        .fetch_err(fetch_err), .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .fetch_start(t_fetch_start), .pc_update(z1),
        .pc_sel(z2), .branch_taken(z1), .imm(z32), .rs1_val(z32),
        .imem_req(t_req), .imem_addr(t_addr), .imem_ready(z1),
        .imem_rvalid(z1), .imem_rdata(z32), .pc(t_pc), .pc_plus4(t_pc4),
        .instr(t_instr), .instr_valid(t_valid), .fetch_busy(t_busy),
        .fetch_err(t_err), .misalign_err(t_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pc_upd(input logic [1:0] sel, input logic bt, input logic [31:0] im,
                          input logic [31:0] rs);
        pc_update    = 1'b1;
        pc_sel       = sel;
        branch_taken = bt;
        imm          = im;
        rs1_val      = rs;
        step();
        pc_update = 1'b0;
    endtask

    // Memory answers: accept now, data next cycle.
    task automatic mem_respond(input logic [31:0] data);
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
    endtask

    // Monitor: every new capture must match the oldest outstanding fetch.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_capture: got instr 0x%08h, required no capture", instr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", imem_addr, e.addr);
                chk("sb_instr", instr, e.data);
            end
        end
        prev_valid <= instr_valid;
    end

    always @(posedge clk) begin
        assert (!(rst_n && fetch_busy && (fetch_start || pc_update)))
            else $error("sequencer strobe while fetch_busy");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; fetch_start = 1'b0; pc_update = 1'b0; pc_sel = 2'b00;
        branch_taken = 1'b0; imm = '0; rs1_val = '0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; t_fetch_start = 1'b0;
        z1 = 1'b0; z2 = 2'b00; z32 = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_pc", pc, 32'h100);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_instr", instr, 32'h13);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_pc4", pc_plus4, 32'h104);

        // Basic fetch: ready at +1, rvalid at +2, capture visible at +3.
        exp_q.push_back('{addr: 32'h100, data: 32'h0050_0093});
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("f1_req", {31'd0, imem_req}, 32'd1);
        chk("f1_busy_n1", {31'd0, fetch_busy}, 32'd1);
        chk("f1_addr", imem_addr, 32'h100);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("f1_req_wait", {31'd0, imem_req}, 32'd0);
        chk("f1_busy_n2", {31'd0, fetch_busy}, 32'd1);
        chk("f1_valid_n2", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        chk("f1_busy_n3", {31'd0, fetch_busy}, 32'd0);
        chk("f1_valid_n3", {31'd0, instr_valid}, 32'd1);

        // Backpressure: ready low 5 cycles, data 3 cycles after acceptance.
        exp_q.push_back('{addr: 32'h100, data: 32'h00A0_0113});
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("bp_req_high", {31'd0, imem_req}, 32'd1);
            chk("bp_addr_req", imem_addr, 32'h100);
            imem_ready = (i == 5);
            step();
        end
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_req_wait", {31'd0, imem_req}, 32'd0);
            chk("bp_addr_wait", imem_addr, 32'h100);
            chk("bp_valid_wait", {31'd0, instr_valid}, 32'd0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0;
        chk("bp_valid", {31'd0, instr_valid}, 32'd1);
        step();
        chk("bp_idle", {31'd0, fetch_busy}, 32'd0);

        // Next-PC sources and misalignment rejection.
        pc_upd(2'b10, 1'b0, 32'h0, 32'h200);
        chk("pc_jalr_200", pc, 32'h200);
        chk("pc_upd_clr_valid", {31'd0, instr_valid}, 32'd0);
        pc_upd(2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0);
        chk("pc_branch_back", pc, 32'h1F0);
        pc_upd(2'b10, 1'b0, 32'h0, 32'h301);
        chk("pc_jalr_clr_lsb", pc, 32'h300);
        chk("mis_none", {31'd0, misalign_err}, 32'd0);
        pc_upd(2'b01, 1'b1, 32'h6, 32'h0);
        chk("mis_pc_hold", pc, 32'h300);
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
        step();
        chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
        pc_upd(2'b01, 1'b0, 32'h6, 32'h0);
        chk("pc_not_taken", pc, 32'h304);
        pc_upd(2'b11, 1'b0, 32'h8, 32'h0);
        chk("pc_hold", pc, 32'h304);
        chk("pc_hold_nomis", {31'd0, misalign_err}, 32'd0);

        // Simultaneous update + fetch uses the new PC.
        pc_upd(2'b10, 1'b0, 32'h0, 32'h10);
        chk("pc_set_10", pc, 32'h10);
        exp_q.push_back('{addr: 32'h14, data: 32'h1111_1111});
        fetch_start = 1'b1;
        pc_upd(2'b00, 1'b0, 32'h0, 32'h0);
        fetch_start = 1'b0;
        chk("sim_pc", pc, 32'h14);
        chk("sim_addr", imem_addr, 32'h14);
        chk("sim_req", {31'd0, imem_req}, 32'd1);
        mem_respond(32'h1111_1111);
        chk("sim_valid", {31'd0, instr_valid}, 32'd1);

        // Simultaneous with misaligned target: fetch uses the old PC.
        exp_q.push_back('{addr: 32'h14, data: 32'h2222_2222});
        fetch_start = 1'b1;
        pc_upd(2'b01, 1'b1, 32'h2, 32'h0);
        fetch_start = 1'b0;
        chk("simmis_pc", pc, 32'h14);
        chk("simmis_addr", imem_addr, 32'h14);
        chk("simmis_pulse", {31'd0, misalign_err}, 32'd1);
        mem_respond(32'h2222_2222);
        chk("simmis_valid", {31'd0, instr_valid}, 32'd1);

        // Reset during WAIT overrides the fetch in flight.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("rw_in_wait", {31'd0, fetch_busy & ~imem_req}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_pc", pc, 32'h100);
        chk("rw_req", {31'd0, imem_req}, 32'd0);
        chk("rw_instr", instr, 32'h13);
        chk("rw_valid", {31'd0, instr_valid}, 32'd0);
        chk("rw_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rw_addr", imem_addr, 32'h100);

        // 32-bit wrap of pc+4.
        pc_upd(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_top", pc_plus4, 32'h0);
        pc_upd(2'b00, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", pc_plus4, 32'h4);
        chk("wrap_nomis", {31'd0, misalign_err}, 32'd0);

        // Timeout instance: four cycles in REQ, then abort.
        t_fetch_start = 1'b1;
        step();
        t_fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", {31'd0, t_req}, 32'd1);
            step();
        end
        chk("to_idle", {31'd0, t_busy}, 32'd0);
        chk("to_req_low", {31'd0, t_req}, 32'd0);
        chk("to_err", {31'd0, t_err}, 32'd1);
        chk("to_instr_kept", t_instr, 32'h13);
        chk("to_valid", {31'd0, t_valid}, 32'd0);
        step();
        chk("to_err_sticky", {31'd0, t_err}, 32'd1);
        t_fetch_start = 1'b1;
        step();
        t_fetch_start = 1'b0;
        chk("to_err_cleared", {31'd0, t_err}, 32'd0);
        chk("to_refetch_req", {31'd0, t_req}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("to_err_again", {31'd0, t_err}, 32'd1);

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
